// File: rtl/vec_exec_pkg.sv
// rtl/vec_exec_pkg.sv - shared types and sizing for the vector execute stage
package vec_exec_pkg;

    localparam int REGISTER_SIZE   = 8;
    localparam int VEC_SIZE        = 16;
    localparam int LANES_PER_CYCLE = 4;
    localparam int SELECTION_BITS  = 2;

    // Number of BUSY cycles a full vector operation needs.
    function automatic int num_chunks();
        return VEC_SIZE / LANES_PER_CYCLE;
    endfunction

    localparam int NUM_CHUNKS = num_chunks();
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LANE_W     = $clog2(VEC_SIZE);

    typedef logic [REGISTER_SIZE-1:0]               elem_t;
    typedef logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] vec_t;
    typedef logic [SELECTION_BITS-1:0]              sel_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vec_exec_unit_if.sv
// rtl/vec_exec_unit_if.sv - operation request and write-back packet bundle
interface vec_exec_if;
    import vec_exec_pkg::*;

    logic    in_valid;
    logic    in_ready;
    alu_op_t op;
    logic    is_scalar;
    sel_t    dst_reg;
    vec_t    operand1;
    vec_t    operand2;

    logic    out_valid;
    logic    out_ready;
    vec_t    wb_data;
    sel_t    wb_reg;
    logic    wb_en_vec;
    logic    wb_en_sc;

    modport master (
        output in_valid, op, is_scalar, dst_reg, operand1, operand2, out_ready,
        input  in_ready, out_valid, wb_data, wb_reg, wb_en_vec, wb_en_sc
    );

    modport slave (
        input  in_valid, op, is_scalar, dst_reg, operand1, operand2, out_ready,
        output in_ready, out_valid, wb_data, wb_reg, wb_en_vec, wb_en_sc
    );

endinterface

// File: rtl/vec_exec_unit_lane_alu.sv
// rtl/vec_exec_unit_lane_alu.sv - combinational single-lane unsigned ALU
module lane_alu
    import vec_exec_pkg::*;
(
    input  elem_t   a,
    input  elem_t   b,
    input  alu_op_t op,
    output elem_t   y
);

    // Shift amounts use only the low three bits of b; MUL keeps the low byte.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = a << b[2:0];
            OP_SHR:  y = a >> b[2:0];
            OP_MUL:  y = a * b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_unit.sv
// rtl/vec_exec_unit.sv - multi-cycle lane-chunked vector execute stage with write-back handshake
module vec_exec_unit
    import vec_exec_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    vec_exec_if.slave bus
);

    state_t              state_q;
    state_t              state_d;
    alu_op_t             op_q;
    logic                scalar_q;
    sel_t                reg_q;
    vec_t                a_q;
    vec_t                b_q;
    vec_t                data_q;
    logic [CHUNK_W-1:0]  chunk_q;

    logic                accept;
    logic                compute;
    logic                last_chunk;

    elem_t               lane_y   [LANES_PER_CYCLE];
    logic [LANE_W-1:0]   lane_idx [LANES_PER_CYCLE];

    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
        assign lane_idx[g] = LANE_W'(chunk_q) * LANE_W'(LANES_PER_CYCLE) + LANE_W'(g);

        lane_alu u_lane_alu (
            .a  (a_q[lane_idx[g]]),
            .b  (b_q[lane_idx[g]]),
            .op (op_q),
            .y  (lane_y[g])
        );
    end

    // Flush outranks every other transition, so nothing is accepted or delivered with it.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        compute    = 1'b0;
        last_chunk = scalar_q || (chunk_q == CHUNK_W'(NUM_CHUNKS - 1));
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    compute = 1'b1;
                    if (last_chunk) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_ADD;
            scalar_q <= 1'b0;
            reg_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            chunk_q  <= '0;
        end else if (flush) begin
            data_q  <= '0;
            chunk_q <= '0;
        end else if (accept) begin
            op_q     <= bus.op;
            scalar_q <= bus.is_scalar;
            reg_q    <= bus.dst_reg;
            a_q      <= bus.operand1;
            b_q      <= bus.operand2;
            data_q   <= '0;
            chunk_q  <= '0;
        end else if (compute) begin
            // Scalar ops run with chunk 0, so lane_y[0] is lane 0's result.
            if (scalar_q) begin
                data_q[0] <= lane_y[0];
            end else begin
                for (int i = 0; i < LANES_PER_CYCLE; i++) begin
                    data_q[lane_idx[i]] <= lane_y[i];
                end
            end
            chunk_q <= chunk_q + 1'b1;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.wb_data   = data_q;
    assign bus.wb_reg    = reg_q;
    assign bus.wb_en_vec = bus.out_valid && !scalar_q;
    assign bus.wb_en_sc  = bus.out_valid && scalar_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// tb/tb_vec_exec_unit.sv - self-checking bench for vec_exec_unit against a lane-wise arithmetic model
module tb_vec_exec_unit;
    import vec_exec_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    vec_exec_if bus ();

    vec_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        int m;
        m = 2 ** REGISTER_SIZE;
        case (op)
            0: return (a + b) % m;
            1: return (a - b + m) % m;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a * (2 ** (b % 8))) % m;
            6: return a / (2 ** (b % 8));
            default: return (a * b) % m;
        endcase
    endfunction

    function automatic vec_t model(input int op, input logic sc, input vec_t a, input vec_t b);
        vec_t r;
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (sc && i > 0) r[i] = '0;
            else r[i] = elem_t'(alu_ref(op, int'(a[i]), int'(b[i])));
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < VEC_SIZE; i++) v[i] = elem_t'($urandom);
        return v;
    endfunction

    function automatic vec_t fill(input elem_t e);
        vec_t v;
        for (int i = 0; i < VEC_SIZE; i++) v[i] = e;
        return v;
    endfunction

    task automatic offer(input alu_op_t op, input logic sc, input sel_t dst, input vec_t a, input vec_t b);
        chk("ready_before_accept", bus.in_ready, 1);
        bus.op        = op;
        bus.is_scalar = sc;
        bus.dst_reg   = dst;
        bus.operand1  = a;
        bus.operand2  = b;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.operand1  = rand_vec();
        bus.operand2  = rand_vec();
        bus.op        = alu_op_t'($urandom_range(0, 7));
        bus.is_scalar = ~sc;
        bus.dst_reg   = ~dst;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    task automatic check_pkt(input string tag, input vec_t exp_data, input sel_t exp_reg, input logic sc);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.wb_data, exp_data);
        chk({tag, "_reg"}, bus.wb_reg, exp_reg);
        chk({tag, "_en_vec"}, bus.wb_en_vec, !sc);
        chk({tag, "_en_sc"}, bus.wb_en_sc, sc);
    endtask

    task automatic deliver(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, bus.out_valid, 0);
        chk({tag, "_ready_back"}, bus.in_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_en_vec"}, bus.wb_en_vec, 0);
        chk({tag, "_en_sc"}, bus.wb_en_sc, 0);
        chk({tag, "_data"}, bus.wb_data, 0);
        chk({tag, "_reg"}, bus.wb_reg, 0);
    endtask

    initial begin
        vec_t    a;
        vec_t    b;
        vec_t    exp_v;
        logic    seen;
        int      opi;
        logic    sc;
        sel_t    dst;
        int      hold;

        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.is_scalar = 1'b0;
        bus.dst_reg   = '0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.out_ready = 1'b0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("reset");

        // vector ADD 0xF0 + 0x20 wraps to 0x10 in every lane
        offer(OP_ADD, 1'b0, 2'd1, fill(8'hF0), fill(8'h20));
        wait_valid("vadd_latency", NUM_CHUNKS);
        check_pkt("vadd", fill(8'h10), 2'd1, 1'b0);
        deliver("vadd");

        // scalar SUB only touches lane 0
        a = rand_vec(); a[0] = 8'h05;
        b = rand_vec(); b[0] = 8'h07;
        exp_v = '0; exp_v[0] = 8'hFE;
        offer(OP_SUB, 1'b1, 2'd2, a, b);
        wait_valid("ssub_latency", 1);
        check_pkt("ssub", exp_v, 2'd2, 1'b1);
        deliver("ssub");

        offer(OP_SHL, 1'b0, 2'd3, fill(8'h81), fill(8'h09));
        wait_valid("shl_latency", NUM_CHUNKS);
        check_pkt("shl", fill(8'h02), 2'd3, 1'b0);
        deliver("shl");

        offer(OP_MUL, 1'b0, 2'd0, fill(8'h10), fill(8'h11));
        wait_valid("mul_latency", NUM_CHUNKS);
        check_pkt("mul", fill(8'h10), 2'd0, 1'b0);
        deliver("mul");

        // backpressure: DONE holds, new offers ignored
        a = rand_vec(); b = rand_vec();
        exp_v = model(int'(OP_SHR), 1'b0, a, b);
        offer(OP_SHR, 1'b0, 2'd2, a, b);
        wait_valid("bp_latency", NUM_CHUNKS);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.operand1 = rand_vec();
            tick();
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_ready", bus.in_ready, 0);
            chk("bp_hold_data", bus.wb_data, exp_v);
        end
        bus.in_valid = 1'b0;
        check_pkt("bp", exp_v, 2'd2, 1'b0);
        deliver("bp");
        tick();
        chk("bp_idle_after", bus.out_valid, 0);

        // flush in the second BUSY cycle with the consumer ready
        offer(OP_ADD, 1'b0, 2'd1, rand_vec(), rand_vec());
        tick();
        flush = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < NUM_CHUNKS + 4; i++) begin
            seen = seen | bus.out_valid;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("flush_busy_no_packet", seen, 0);
        a = rand_vec(); b = rand_vec();
        exp_v = model(int'(OP_XOR), 1'b0, a, b);
        offer(OP_XOR, 1'b0, 2'd3, a, b);
        wait_valid("xor_latency", NUM_CHUNKS);
        check_pkt("xor", exp_v, 2'd3, 1'b0);
        deliver("xor");

        // flush beats an offer in IDLE
        bus.in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle_not_accepted", bus.in_ready, 1);

        // flush beats out_ready in DONE
        offer(OP_OR, 1'b1, 2'd1, rand_vec(), rand_vec());
        wait_valid("sor_latency", 1);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_done_valid", bus.out_valid, 0);
        chk("flush_done_ready", bus.in_ready, 1);

        for (int k = 0; k < 24; k++) begin
            opi  = int'($urandom_range(0, 7));
            sc   = 1'($urandom_range(0, 1));
            dst  = sel_t'($urandom);
            a    = rand_vec();
            b    = rand_vec();
            hold = int'($urandom_range(0, 3));
            exp_v = model(opi, sc, a, b);
            offer(alu_op_t'(opi), sc, dst, a, b);
            wait_valid("rand_latency", sc ? 1 : NUM_CHUNKS);
            for (int h = 0; h < hold; h++) tick();
            check_pkt("rand", exp_v, dst, sc);
            deliver("rand");
        end

        // reset while a packet is waiting
        offer(OP_AND, 1'b0, 2'd3, rand_vec(), rand_vec());
        wait_valid("rst_done_latency", NUM_CHUNKS);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("reset_in_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
